// File: rtl/tpfu_pkg.sv
// Shared opcodes, FSM states and instruction-field helpers for the TP-FU core.
package tpfu_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_NOP2 = 3'b100;
    localparam logic [2:0] OP_ADDI = 3'b101;
    localparam logic [2:0] OP_SUBI = 3'b110;
    localparam logic [2:0] OP_MULI = 3'b111;

    localparam int ALU_LAT = 3;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_EXEC, ST_DRAIN} state_t;
    typedef enum logic [1:0] {FN_ADD, FN_SUB, FN_MUL} alu_fn_t;

    typedef struct packed {
        logic    valid;
        logic    use_imm;
        alu_fn_t fn;
    } decode_t;

    // Instruction layout is {opcode[5:0], dst, src1, src2/imm}, each field RA_W wide.
    function automatic int f_inst_w(input int ra_w);
        return 6 + 3 * ra_w;
    endfunction

    function automatic int f_op_lsb(input int ra_w);
        return 3 * ra_w;
    endfunction

    function automatic int f_dst_lsb(input int ra_w);
        return 2 * ra_w;
    endfunction

    function automatic int f_src1_lsb(input int ra_w);
        return ra_w;
    endfunction

    function automatic int f_src2_lsb(input int ra_w);
        return 0 * ra_w;
    endfunction

    // Only the low three opcode bits select the operation.
    function automatic decode_t f_decode(input logic [5:0] op);
        decode_t d;
        d = '{valid: 1'b0, use_imm: 1'b0, fn: FN_ADD};
        casez (op)
            {3'b???, OP_ADD}:  d = '{valid: 1'b1, use_imm: 1'b0, fn: FN_ADD};
            {3'b???, OP_SUB}:  d = '{valid: 1'b1, use_imm: 1'b0, fn: FN_SUB};
            {3'b???, OP_MUL}:  d = '{valid: 1'b1, use_imm: 1'b0, fn: FN_MUL};
            {3'b???, OP_ADDI}: d = '{valid: 1'b1, use_imm: 1'b1, fn: FN_ADD};
            {3'b???, OP_SUBI}: d = '{valid: 1'b1, use_imm: 1'b1, fn: FN_SUB};
            {3'b???, OP_MULI}: d = '{valid: 1'b1, use_imm: 1'b1, fn: FN_MUL};
            default:           d = '{valid: 1'b0, use_imm: 1'b0, fn: FN_ADD};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/tpfu_alu.sv
// Three-stage add/sub/mul pipeline (input regs, operate, output reg) with valid and
// destination tags travelling alongside the data; the shape matches a DSP48 A/M/P chain.
module tpfu_alu
    import tpfu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int RA_W   = 6
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_v,
    input  logic [1:0]        fn,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [RA_W-1:0]   dst,
    output logic              out_v,
    output logic [DATA_W-1:0] out_data,
    output logic [RA_W-1:0]   out_dst
);

    logic              v1, v2, v3;
    logic [1:0]        fn1;
    logic [DATA_W-1:0] a1, b1, r2, r3, res;
    logic [RA_W-1:0]   d1, d2, d3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            r3 <= '0;
        end else begin
            v1 <= in_v;
            v2 <= v1;
            v3 <= v2;
            r3 <= r2;
        end
    end

    // Data path registers carry no reset so they pack into the DSP pipeline registers.
    always_ff @(posedge clk) begin
        fn1 <= fn;
        a1  <= a;
        b1  <= b;
        d1  <= dst;
        r2  <= res;
        d2  <= d1;
        d3  <= d2;
    end

    always_comb begin
        res = '0;
        case (fn1)
            FN_ADD:  res = a1 + b1;
            FN_SUB:  res = a1 - b1;
            FN_MUL:  res = a1 * b1;
            default: res = '0;
        endcase
    end

    assign out_v    = v3;
    assign out_data = r3;
    assign out_dst  = d3;

endmodule

// File: rtl/tpfu_core.sv
// Temporally programmed FU: loads a sample burst into the register file, then runs
// the stored instruction sequence through the ALU pipeline with result writeback.
module tpfu_core
    import tpfu_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int RA_W       = 6,
    parameter int PROG_DEPTH = 16,
    parameter int PA_W       = $clog2(PROG_DEPTH),
    localparam int INST_W    = f_inst_w(RA_W)
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [PA_W-1:0]   prog_addr,
    input  logic [INST_W-1:0] prog_data,
    input  logic [PA_W:0]     prog_len,
    input  logic [DATA_W-1:0] din,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] dout,
    output logic              dout_v,
    output logic              busy,
    output logic              done
);

    localparam int NREG = 2 ** RA_W;

    logic [DATA_W-1:0] rf   [NREG];
    logic [INST_W-1:0] imem [PROG_DEPTH];

    state_t            state, state_nx;
    logic [PA_W:0]     pc, pc_nx, len_q, len_nx;
    logic [RA_W-1:0]   wcnt, wcnt_nx;
    logic [1:0]        drain_cnt, drain_nx;

    logic              accept;
    logic [INST_W-1:0] cur_inst;
    logic [5:0]        cur_op;
    logic [RA_W-1:0]   cur_dst, cur_src1, cur_src2;
    decode_t           dec;
    logic              issue_v;
    logic [DATA_W-1:0] opa, opb;
    logic              wb_v;
    logic [DATA_W-1:0] wb_data;
    logic [RA_W-1:0]   wb_dst;

    assign in_ready = (state == ST_IDLE) || (state == ST_LOAD);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DRAIN) && (drain_cnt == 2'(ALU_LAT));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            pc        <= '0;
            len_q     <= '0;
            wcnt      <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            len_q     <= len_nx;
            wcnt      <= wcnt_nx;
            drain_cnt <= drain_nx;
        end
    end

    // wcnt is the next register to fill; it is zero in IDLE so the first sample lands in R0.
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        len_nx   = len_q;
        wcnt_nx  = wcnt;
        drain_nx = drain_cnt;
        case (state)
            ST_IDLE, ST_LOAD: begin
                if (accept) begin
                    wcnt_nx  = wcnt + 1'b1;
                    state_nx = ST_LOAD;
                    if (in_last || (wcnt == '1)) begin
                        wcnt_nx  = '0;
                        pc_nx    = '0;
                        len_nx   = prog_len;
                        state_nx = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                pc_nx = pc + 1'b1;
                if ((len_q == '0) || (pc_nx == len_q)) begin
                    state_nx = ST_DRAIN;
                    drain_nx = '0;
                end
            end
            ST_DRAIN: begin
                drain_nx = drain_cnt + 1'b1;
                if (drain_cnt == 2'(ALU_LAT)) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (prog_we && (state == ST_IDLE)) begin
            imem[prog_addr] <= prog_data;
        end
    end

    assign cur_inst = imem[pc[PA_W-1:0]];
    assign cur_op   = cur_inst[f_op_lsb(RA_W) +: 6];
    assign cur_dst  = cur_inst[f_dst_lsb(RA_W) +: RA_W];
    assign cur_src1 = cur_inst[f_src1_lsb(RA_W) +: RA_W];
    assign cur_src2 = cur_inst[f_src2_lsb(RA_W) +: RA_W];
    assign dec      = f_decode(cur_op);

    // Operands are read in the issue cycle with no forwarding from the pipeline.
    assign issue_v = (state == ST_EXEC) && (len_q != '0) && dec.valid;
    assign opa     = rf[cur_src1];
    assign opb     = dec.use_imm ? DATA_W'(cur_src2) : rf[cur_src2];

    tpfu_alu #(
        .DATA_W (DATA_W),
        .RA_W   (RA_W)
    ) u_alu (
        .clk      (clk),
        .rst      (rst),
        .in_v     (issue_v),
        .fn       (dec.fn),
        .a        (opa),
        .b        (opb),
        .dst      (cur_dst),
        .out_v    (wb_v),
        .out_data (wb_data),
        .out_dst  (wb_dst)
    );

    // Sample loads and writebacks never overlap: the pipeline is empty outside EXEC/DRAIN.
    always_ff @(posedge clk) begin
        if (wb_v) begin
            rf[wb_dst] <= wb_data;
        end else if (accept) begin
            rf[wcnt] <= din;
        end
    end

    assign dout   = wb_data;
    assign dout_v = wb_v;

endmodule

// File: tb/tb_tpfu_core.sv
// Scoreboard bench for tpfu_core: directed bursts push expected results, a monitor
// pops and compares them whenever dout_v is seen.
module tb_tpfu_core;
    import tpfu_pkg::*;

    localparam int DATA_W     = 16;
    localparam int RA_W       = 6;
    localparam int PROG_DEPTH = 16;
    localparam int PA_W       = 4;
    localparam int INST_W     = 24;

    logic              clk, rst;
    logic              prog_we;
    logic [PA_W-1:0]   prog_addr;
    logic [INST_W-1:0] prog_data;
    logic [PA_W:0]     prog_len;
    logic [DATA_W-1:0] din, dout;
    logic              in_valid, in_last, in_ready, dout_v, busy, done;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;

    exp_t              exp_q[$];
    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    int                done_cnt = 0;
    int                last_done_cyc = -1;
    logic [DATA_W-1:0] burst [64];

    tpfu_core #(
        .DATA_W     (DATA_W),
        .RA_W       (RA_W),
        .PROG_DEPTH (PROG_DEPTH),
        .PA_W       (PA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_len  (prog_len),
        .din       (din),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .dout      (dout),
        .dout_v    (dout_v),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
        end
    endtask

    // Monitor: pops the scoreboard on every dout_v and counts done pulses.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (dout_v === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_dout: actual=%0h required=no output", dout);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("dout", 32'(dout), 32'(e.data));
                    if (e.cyc >= 0) checkOutput("dout_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [INST_W-1:0] mk(input logic [5:0] op, input int dst, input int src1, input int src2);
        logic [5:0] d, s1, s2;
        d  = 6'(dst);
        s1 = 6'(src1);
        s2 = 6'(src2);
        return {op, d, s1, s2};
    endfunction

    task automatic load_inst(input int addr, input logic [INST_W-1:0] inst);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = PA_W'(addr);
        prog_data = inst;
        @(negedge clk);
        prog_we   = 1'b0;
    endtask

    // Sends burst[0..n-1]; acc is the cycle count right after the last sample's accept edge.
    task automatic applyStimulus(input int n, input bit use_last, output int acc);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            din      = burst[i];
            in_valid = 1'b1;
            in_last  = use_last && (i == n - 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        acc      = cyc;
    endtask

    task automatic push_exp(input logic [DATA_W-1:0] data, input int at_cyc);
        exp_q.push_back('{data, at_cyc});
    endtask

    task automatic wait_done(input string name, input int budget, output int dcyc);
        int start;
        start = done_cnt;
        for (int i = 0; i < budget && done_cnt == start; i++) @(negedge clk);
        #1;
        dcyc = last_done_cyc;
        repeat (3) @(negedge clk);
        checkOutput({name, "_done_pulses"}, 32'(done_cnt - start), 32'd1);
        checkOutput({name, "_results_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int acc, dc;
        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_len = '0;
        din = '0; in_valid = 1'b0; in_last = 1'b0;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_dout", 32'(dout), 32'd0);
        checkOutput("reset_dout_v", 32'(dout_v), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

        // Scaled samples; instruction 1 sets the ignored opcode bits.
        load_inst(0, mk(6'b000111,  8, 0, 1));
        load_inst(1, mk(6'b101111,  9, 0, 16));
        load_inst(2, mk(6'b000111, 10, 2, 16));
        load_inst(3, mk(6'b000111, 11, 3, 16));
        prog_len = 5'd4;
        burst[0] = 16'd3; burst[1] = 16'd5; burst[2] = 16'd7; burst[3] = 16'd9;
        applyStimulus(4, 1'b1, acc);
        push_exp(16'd3,   acc + 3);
        push_exp(16'd48,  acc + 4);
        push_exp(16'd112, acc + 5);
        push_exp(16'd144, acc + 6);
        checkOutput("a_busy_exec", 32'(busy), 32'd1);
        checkOutput("a_in_ready_exec", 32'(in_ready), 32'd0);
        wait_done("a", 30, dc);
        checkOutput("a_done_cycle", 32'(dc), 32'(acc + 7));
        checkOutput("a_in_ready_idle", 32'(in_ready), 32'd1);

        // Writeback visible to an instruction issued four cycles after its producer.
        load_inst(0, mk(6'b000001, 4, 0, 1));
        load_inst(1, mk(6'b000000, 6, 0, 1));
        load_inst(2, mk(6'b000100, 6, 0, 1));
        load_inst(3, mk(6'b111000, 6, 0, 1));
        load_inst(4, mk(6'b000011, 5, 4, 4));
        prog_len = 5'd5;
        burst[0] = 16'd2; burst[1] = 16'd3;
        applyStimulus(2, 1'b1, acc);
        push_exp(16'd5, -1);
        push_exp(16'd25, -1);
        wait_done("b", 30, dc);

        // Back-to-back dependency reads the stale R4 loaded by the burst.
        load_inst(1, mk(6'b000011, 5, 4, 4));
        prog_len = 5'd2;
        burst[0] = 16'd2; burst[1] = 16'd3; burst[2] = 16'd0; burst[3] = 16'd0; burst[4] = 16'd2;
        applyStimulus(5, 1'b1, acc);
        push_exp(16'd5, -1);
        push_exp(16'd4, -1);
        wait_done("c", 30, dc);

        // Wrap-around arithmetic and immediates.
        load_inst(0, mk(6'b000001, 2, 0, 1));
        load_inst(1, mk(6'b000010, 3, 1, 0));
        load_inst(2, mk(6'b000011, 4, 0, 1));
        load_inst(3, mk(6'b000110, 7, 1, 5));
        load_inst(4, mk(6'b000101, 6, 2, 0));
        load_inst(5, mk(6'b000101, 8, 0, 63));
        prog_len = 5'd6;
        burst[0] = 16'hFFFF; burst[1] = 16'd2;
        applyStimulus(2, 1'b1, acc);
        push_exp(16'h0001, acc + 3);
        push_exp(16'h0003, acc + 4);
        push_exp(16'hFFFE, acc + 5);
        push_exp(16'hFFFD, acc + 6);
        push_exp(16'h0001, acc + 7);
        push_exp(16'h003E, acc + 8);
        wait_done("d", 30, dc);

        // Fill all 64 registers with no in_last; R63 is read back through ADDI.
        load_inst(0, mk(6'b000101, 62, 63, 0));
        prog_len = 5'd1;
        for (int i = 0; i < 64; i++) burst[i] = 16'(i * 7 + 100);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (i == 63) checkOutput("e_ready_before_full", 32'(in_ready), 32'd1);
            din      = burst[i];
            in_valid = 1'b1;
            in_last  = 1'b0;
        end
        @(negedge clk);
        acc = cyc;
        in_valid = 1'b0;
        push_exp(16'd541, acc + 3);
        checkOutput("e_ready_after_full", 32'(in_ready), 32'd0);
        checkOutput("e_busy_exec", 32'(busy), 32'd1);
        wait_done("e", 20, dc);

        // Reset mid-EXEC aborts the run; imem survives for the next burst.
        for (int k = 0; k < 8; k++) load_inst(k, mk(6'b000101, 10 + k, 0, k));
        prog_len = 5'd8;
        burst[0] = 16'd100;
        applyStimulus(1, 1'b1, acc);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("f_rst_dout_v", 32'(dout_v), 32'd0);
        checkOutput("f_rst_busy", 32'(busy), 32'd0);
        checkOutput("f_rst_dout", 32'(dout), 32'd0);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("f_idle_after_rst", 32'(in_ready), 32'd1);
        burst[0] = 16'd7;
        applyStimulus(1, 1'b1, acc);
        for (int k = 0; k < 8; k++) push_exp(16'(7 + k), acc + 3 + k);
        prog_we   = 1'b1;
        prog_addr = 4'd7;
        prog_data = mk(6'b000111, 0, 0, 0);
        @(negedge clk);
        prog_we = 1'b0;
        wait_done("f", 30, dc);

        // Empty program: a drain-length wait and a single done, no results.
        prog_len = 5'd0;
        burst[0] = 16'h0055;
        applyStimulus(1, 1'b1, acc);
        checkOutput("g_busy", 32'(busy), 32'd1);
        wait_done("g", 20, dc);
        checkOutput("g_done_cycle", 32'(dc), 32'(acc + 4));
        checkOutput("g_in_ready", 32'(in_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
